instr_encoder: RTL
==================

# instr_encoder

Pipelined RV64 instruction encoder: the inverse of the fetch-side decoder. Accepts decoded instruction fields (format, opcode, funct3, funct7, register indices, signed immediate) over a valid/ready handshake. Packs them into the 32-bit RISC-V machine word, checks the fields for encodability, and presents results in order through a small output FIFO. Used by the self-test instruction generator and by the decoder round-trip bench.

## Interface
- INSTRSZ, 32, instruction word width
- REGBITS, 5, register index width
- DEPTH, 2, output FIFO entries (power of two, ≥2)
- clk  in  1  clock; all state on posedge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input fields valid
- in_ready  out  1  encoder can accept; in_ready = !reset && (fifo_count < DEPTH)
- in_fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6,7 illegal
- in_opcode  in  7  major opcode
- in_funct3  in  3  funct3
- in_funct7  in  7  funct7 (R format; I-format shifts)
- in_rd, in_rs1, in_rs2  in  REGBITS each  register indices
- in_imm  in  32  signed byte-offset/immediate, already sign-extended
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer takes the head
- out_instr  out  INSTRSZ  encoded word at the head
- out_illegal  out  1  head fields were not encodable
- enc_count  out  16  legal instructions accepted since reset; wraps

## Operation
- Accept when in_valid && in_ready. The encoded word and illegal flag are computed combinationally and written to the FIFO tail on the same edge.
- R: {funct7, rs2, rs1, funct3, rd, opcode}.
- I: {imm[11:0], rs1, funct3, rd, opcode}. Exception: shift forms (opcode 0010011 or 0011011, funct3 001/101) use {funct7, imm[4:0], rs1, funct3, rd, opcode}.
- S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
- B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
- U: {imm[31:12], rd, opcode}.
- J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
- Illegal if any of the following holds:
  - in_fmt > 5
  - opcode[1:0] != 2'b11
  - I/S, non-shift: imm[31:11] not all equal
  - I shift: imm[31:5] != 0
  - B: imm[31:12] not all equal, or imm[0] = 1
  - J: imm[31:20] not all equal, or imm[0] = 1
  - U: imm[11:0] != 0
- An illegal entry is still enqueued, with the word packed from the truncated fields and out_illegal = 1. It does not increment enc_count.
- FIFO: DEPTH entries, read/write pointers wrap modulo DEPTH, and fifo_count has DEPTH+1 states.
  - Push and pop in the same cycle leave the count unchanged.
  - Pop when out_valid && out_ready.
  - Output is strict FIFO order, no reordering.
- Full: in_ready = 0, computed from the registered count. A pop in the same cycle does not re-enable acceptance until the next cycle.
- Empty: out_valid = 0. out_instr and out_illegal hold their last value (0 after reset).
- enc_count increments by 1 per accepted legal instruction and wraps 0xFFFF → 0x0000.

## Timing
- Latency: an accept at edge N gives out_valid = 1 after edge N when the FIFO was empty. No combinational path from in_* to out_*.
- Throughput: one instruction per cycle while out_ready = 1.
- out_valid, out_instr and out_illegal are stable while out_valid && !out_ready.
- in_ready depends only on registered state and reset. It does not depend on in_valid.
- Reset, including mid-stream, takes effect at the next edge: fifo_count = 0, pointers = 0, out_valid = 0, out_instr = 0, out_illegal = 0, enc_count = 0.
  - in_ready = 0 while reset is high.
  - Any input presented during reset is dropped; queued entries are discarded.

## Test plan
- R ADD x3,x1,x2 (fmt 0, op 0110011, f3 0, f7 0) → out_instr 0x002081B3, out_illegal 0, enc_count 1.
- I ADDI x1,x0,-1 (imm 0xFFFFFFFF) → 0xFFF00093. ADDI imm 2048 → out_illegal 1, enc_count unchanged.
- B BEQ x1,x2,+8 → 0x00208463. J JAL x1,+2048 → 0x001000EF. BEQ imm 3 → illegal.
- Backpressure: out_ready = 0, offer 3 back-to-back instructions.
  - in_ready falls after 2 accepts.
  - Raise out_ready: the 3rd is accepted one cycle after the first pop.
  - All outputs emerge in order, with the head held stable while stalled.
- Reset asserted with 2 entries queued → next cycle out_valid 0, enc_count 0, in_ready 0. One cycle after reset deasserts, in_ready 1.
- Drive 65536 legal encodes → enc_count wraps to 0. Random fields compared against a reference packing model and decoder round-trip.

Source files
------------

// File: rtl/instr_encoder.sv
// RV64 instruction encoder: packs decoded fields into a 32-bit machine word,
// flags unencodable fields, and queues results in order through a small FIFO.
module instr_encoder #(
    parameter int INSTRSZ = 32,
    parameter int REGBITS = 5,
    parameter int DEPTH   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_fmt,
    input  logic [6:0]         in_opcode,
    input  logic [2:0]         in_funct3,
    input  logic [6:0]         in_funct7,
    input  logic [REGBITS-1:0] in_rd,
    input  logic [REGBITS-1:0] in_rs1,
    input  logic [REGBITS-1:0] in_rs2,
    input  logic [31:0]        in_imm,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTRSZ-1:0] out_instr,
    output logic               out_illegal,
    output logic [15:0]        enc_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    typedef struct packed {
        logic               illegal;
        logic [INSTRSZ-1:0] instr;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          enc;
    entry_t          last;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            push, pop;
    logic            is_shift, bad_fields;
    logic            sext11, sext12, sext20;

    // Immediate range checks: upper bits must be pure sign extension.
    assign sext11 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign sext12 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
    assign sext20 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

    assign is_shift = (in_fmt == FMT_I)
                   && (in_opcode == 7'b0010011 || in_opcode == 7'b0011011)
                   && (in_funct3[1:0] == 2'b01);

    always_comb begin
        enc.instr  = '0;
        bad_fields = 1'b0;
        case (in_fmt)
            FMT_R: enc.instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            FMT_I: begin
                if (is_shift) begin
                    enc.instr  = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
                    bad_fields = |in_imm[31:5];
                end else begin
                    enc.instr  = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                    bad_fields = !sext11;
                end
            end
            FMT_S: begin
                enc.instr  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                bad_fields = !sext11;
            end
            FMT_B: begin
                enc.instr  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                              in_imm[4:1], in_imm[11], in_opcode};
                bad_fields = !sext12 || in_imm[0];
            end
            FMT_U: begin
                enc.instr  = {in_imm[31:12], in_rd, in_opcode};
                bad_fields = |in_imm[11:0];
            end
            FMT_J: begin
                enc.instr  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
                bad_fields = !sext20 || in_imm[0];
            end
            // Unknown formats still enqueue an R-shaped word so the slot is traceable.
            default: begin
                enc.instr  = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
                bad_fields = 1'b1;
            end
        endcase
        enc.illegal = bad_fields || (in_opcode[1:0] != 2'b11);
    end

    assign in_ready  = !reset && (count < CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // When drained, the outputs keep showing the most recently popped entry.
    assign out_instr   = out_valid ? mem[rd_ptr].instr   : last.instr;
    assign out_illegal = out_valid ? mem[rd_ptr].illegal : last.illegal;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            last      <= '0;
            enc_count <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= enc;
                wr_ptr      <= wr_ptr + PW'(1);
                if (!enc.illegal)
                    enc_count <= enc_count + 16'd1;
            end
            if (pop) begin
                last   <= mem[rd_ptr];
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
